// File: rtl/cv32e40s_pkg.sv
// Shared types for the iterative carry-less multiplier.
// b_ext_e        : bitmanip configuration; only ZBA_ZBB_ZBC_ZBS enables the unit
// clmul_op_e     : clmul / clmulh / clmulr operator encoding
// clmul_state_e  : controller states
// clmul_select() : pick the 32-bit result window out of the 64-bit product
package cv32e40s_pkg;

    typedef enum logic [1:0] {
        B_NONE          = 2'b00,
        ZBA_ZBB         = 2'b01,
        ZBA_ZBB_ZBS     = 2'b10,
        ZBA_ZBB_ZBC_ZBS = 2'b11
    } b_ext_e;

    typedef enum logic [1:0] {
        CLMUL_LO  = 2'b00,
        CLMUL_HI  = 2'b01,
        CLMUL_REV = 2'b10
    } clmul_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } clmul_state_e;

    function automatic logic [31:0] clmul_select(input logic [63:0] prod, input clmul_op_e op);
        logic [31:0] res;
        case (op)
            CLMUL_LO:  res = prod[31:0];
            CLMUL_HI:  res = prod[63:32];
            CLMUL_REV: res = prod[62:31];
            default:   res = 32'h0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cv32e40s_clmul_step.sv
// One iteration of the carry-less multiply: folds STEP partial products into
// the accumulator.
// acc_i : running 64-bit accumulator
// a_i   : rs1 already shifted to the weight of b_i[0]
// b_i   : the STEP rs2 bits handled this cycle
// acc_o : acc_i XOR (a_i << j) for every set b_i[j]
module cv32e40s_clmul_step #(
    parameter int STEP = 4
) (
    input  logic [63:0]     acc_i,
    input  logic [63:0]     a_i,
    input  logic [STEP-1:0] b_i,
    output logic [63:0]     acc_o
);

    always_comb begin
        acc_o = acc_i;
        for (int j = 0; j < STEP; j++) begin
            if (b_i[j]) begin
                acc_o = acc_o ^ (a_i << j);
            end
        end
    end

endmodule

// File: rtl/cv32e40s_clmul_iter.sv
// Iterative carry-less multiplier for clmul / clmulh / clmulr.
// clk, rst_n           : clock, synchronous active-low reset
// valid_i / ready_o    : request handshake (accepted only in IDLE)
// operator_i, op_a_i,
// op_b_i               : operator, rs1, rs2
// kill_i               : flush; returns to IDLE from any state, beats valid_i/ready_i
// valid_o / ready_i    : result handshake
// result_o             : result, forced to zero while valid_o is low
//
// state | meaning
// IDLE  | waiting for a request, ready_o high
// BUSY  | consuming STEP rs2 bits per cycle
// DONE  | result held on result_o until ready_i
module cv32e40s_clmul_iter
    import cv32e40s_pkg::*;
#(
    parameter b_ext_e B_EXT      = B_NONE,
    parameter int     STEP       = 4,
    parameter bit     EARLY_TERM = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    output logic        ready_o,
    input  clmul_op_e   operator_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        kill_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] result_o
);

    if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8 || STEP == 16 || STEP == 32)) begin : g_bad_step
        $error("cv32e40s_clmul_iter: STEP must be 1, 2, 4, 8, 16 or 32");
    end

    if (B_EXT == ZBA_ZBB_ZBC_ZBS) begin : g_zbc

        localparam int                CNT_W    = $clog2(32 / STEP) + 1;
        localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(32 / STEP - 1);

        clmul_state_e      state_q;
        logic              ready_q;
        logic              valid_q;
        logic [31:0]       result_q;
        logic [63:0]       acc_q;
        logic [63:0]       a_sh_q;
        logic [31:0]       b_rem_q;
        logic [CNT_W-1:0]  cnt_q;
        clmul_op_e         op_q;

        logic [63:0]       acc_d;
        logic [63:0]       a_sh_d;
        logic [31:0]       b_rem_d;
        logic              finish;

        cv32e40s_clmul_step #(
            .STEP (STEP)
        ) u_step (
            .acc_i (acc_q),
            .a_i   (a_sh_q),
            .b_i   (b_rem_q[STEP-1:0]),
            .acc_o (acc_d)
        );

        assign a_sh_d  = a_sh_q << STEP;
        assign b_rem_d = b_rem_q >> STEP;
        // Early exit once no set rs2 bits remain beyond this cycle's slice.
        assign finish  = (cnt_q == CNT_LAST) || (EARLY_TERM && (b_rem_d == 32'h0));

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_q  <= IDLE;
                ready_q  <= 1'b1;
                valid_q  <= 1'b0;
                result_q <= 32'h0;
                acc_q    <= 64'h0;
                a_sh_q   <= 64'h0;
                b_rem_q  <= 32'h0;
                cnt_q    <= '0;
                op_q     <= CLMUL_LO;
            end else if (kill_i) begin
                state_q  <= IDLE;
                ready_q  <= 1'b1;
                valid_q  <= 1'b0;
                result_q <= 32'h0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (valid_i) begin
                            a_sh_q  <= {32'h0, op_a_i};
                            b_rem_q <= op_b_i;
                            acc_q   <= 64'h0;
                            cnt_q   <= '0;
                            op_q    <= operator_i;
                            state_q <= BUSY;
                            ready_q <= 1'b0;
                        end
                    end
                    BUSY: begin
                        acc_q   <= acc_d;
                        a_sh_q  <= a_sh_d;
                        b_rem_q <= b_rem_d;
                        if (finish) begin
                            // Counter parks at zero so it never passes CNT_LAST.
                            cnt_q    <= '0;
                            state_q  <= DONE;
                            valid_q  <= 1'b1;
                            result_q <= clmul_select(acc_d, op_q);
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    DONE: begin
                        if (ready_i) begin
                            state_q  <= IDLE;
                            ready_q  <= 1'b1;
                            valid_q  <= 1'b0;
                            result_q <= 32'h0;
                        end
                    end
                    default: begin
                        state_q  <= IDLE;
                        ready_q  <= 1'b1;
                        valid_q  <= 1'b0;
                        result_q <= 32'h0;
                    end
                endcase
            end
        end

        assign ready_o  = ready_q;
        assign valid_o  = valid_q;
        assign result_o = result_q;

        a_no_dual_valid_ready : assert property (@(posedge clk) disable iff (!rst_n) !(valid_o && ready_o));
        a_result_zero_idle    : assert property (@(posedge clk) disable iff (!rst_n) valid_o || (result_o == 32'h0));
        a_cnt_range           : assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= CNT_LAST);

    end else begin : g_no_zbc

        logic unused_inputs;
        assign unused_inputs = ^{clk, rst_n, valid_i, operator_i, op_a_i, op_b_i, kill_i, ready_i};

        assign ready_o  = 1'b0;
        assign valid_o  = 1'b0;
        assign result_o = 32'h0;

    end

endmodule

// File: tb/tb_cv32e40s_clmul_iter.sv
module tb_cv32e40s_clmul_iter;
    import cv32e40s_pkg::*;

    // Instances 0..5: STEP = 1<<k, no early termination.
    // Instance 6: STEP = 4 with early termination. Instance 7: Zbc absent.
    localparam int NI = 8;

    logic        clk;
    logic        rst_n;
    logic        valid_a  [NI];
    logic        ready_oa [NI];
    clmul_op_e   op_a     [NI];
    logic [31:0] a_a      [NI];
    logic [31:0] b_a      [NI];
    logic        kill_a   [NI];
    logic        valid_oa [NI];
    logic        ready_a  [NI];
    logic [31:0] res_a    [NI];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 6; g++) begin : g_step
        cv32e40s_clmul_iter #(
            .B_EXT      (ZBA_ZBB_ZBC_ZBS),
            .STEP       (1 << g),
            .EARLY_TERM (1'b0)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .valid_i    (valid_a[g]),
            .ready_o    (ready_oa[g]),
            .operator_i (op_a[g]),
            .op_a_i     (a_a[g]),
            .op_b_i     (b_a[g]),
            .kill_i     (kill_a[g]),
            .valid_o    (valid_oa[g]),
            .ready_i    (ready_a[g]),
            .result_o   (res_a[g])
        );
    end

    cv32e40s_clmul_iter #(
        .B_EXT      (ZBA_ZBB_ZBC_ZBS),
        .STEP       (4),
        .EARLY_TERM (1'b1)
    ) u_dut_et (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_i    (valid_a[6]),
        .ready_o    (ready_oa[6]),
        .operator_i (op_a[6]),
        .op_a_i     (a_a[6]),
        .op_b_i     (b_a[6]),
        .kill_i     (kill_a[6]),
        .valid_o    (valid_oa[6]),
        .ready_i    (ready_a[6]),
        .result_o   (res_a[6])
    );

    cv32e40s_clmul_iter #(
        .B_EXT      (ZBA_ZBB),
        .STEP       (4),
        .EARLY_TERM (1'b1)
    ) u_dut_nozbc (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_i    (valid_a[7]),
        .ready_o    (ready_oa[7]),
        .operator_i (op_a[7]),
        .op_a_i     (a_a[7]),
        .op_b_i     (b_a[7]),
        .kill_i     (kill_a[7]),
        .valid_o    (valid_oa[7]),
        .ready_i    (ready_a[7]),
        .result_o   (res_a[7])
    );

    // Reference: full 64-bit carry-less product, then window by operator.
    function automatic logic [31:0] ref_clmul(input clmul_op_e op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'h0;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) p = p ^ ({32'h0, a} << i);
        end
        case (op)
            CLMUL_LO:  return p[31:0];
            CLMUL_HI:  return p[63:32];
            CLMUL_REV: return p[62:31];
            default:   return 32'h0;
        endcase
    endfunction

    function automatic int ref_lat(input int step, input bit et, input logic [31:0] b);
        int msb;
        int n;
        if (!et) return 32 / step;
        msb = -1;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) msb = i;
        end
        n = (msb + 1 + step - 1) / step;
        return (n < 1) ? 1 : n;
    endfunction

    function automatic int step_of(input int k);
        return (k < 6) ? (1 << k) : 4;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Presents a request at a negedge and returns at the negedge after the accepting edge.
    task automatic issue(input int k, input clmul_op_e op, input logic [31:0] a, input logic [31:0] b);
        op_a[k]    = op;
        a_a[k]     = a;
        b_a[k]     = b;
        valid_a[k] = 1'b1;
        tick();
        valid_a[k] = 1'b0;
    endtask

    task automatic wait_valid(input int k, output int lat);
        lat = 0;
        while (!valid_oa[k] && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_op(input int k, input clmul_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat, input string name);
        int lat;
        ready_a[k] = 1'b1;
        chk({name, "_ready_before"}, 64'(ready_oa[k]), 64'd1);
        issue(k, op, a, b);
        wait_valid(k, lat);
        chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({name, "_result"}, 64'(res_a[k]), 64'(exp_res));
        tick();
        chk({name, "_ready_after"}, 64'(ready_oa[k]), 64'd1);
    endtask

    typedef struct {
        int          k;
        clmul_op_e   op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int           lat;
        int           k;
        bit           rose;
        logic [31:0]  held;
        clmul_op_e    rop;
        logic [31:0]  ra;
        logic [31:0]  rb;

        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            valid_a[i] = 1'b0;
            kill_a[i]  = 1'b0;
            ready_a[i] = 1'b1;
            op_a[i]    = CLMUL_LO;
            a_a[i]     = 32'h0;
            b_a[i]     = 32'h0;
        end

        vecs.push_back('{2, CLMUL_LO,  32'h00000003, 32'h00000003, 32'h00000005, 8});
        vecs.push_back('{2, CLMUL_HI,  32'h00000003, 32'h00000003, 32'h00000000, 8});
        for (int s = 0; s < 6; s++) begin
            vecs.push_back('{s, CLMUL_LO,  32'h80000000, 32'h80000000, 32'h00000000, 32 >> s});
            vecs.push_back('{s, CLMUL_HI,  32'h80000000, 32'h80000000, 32'h40000000, 32 >> s});
            vecs.push_back('{s, CLMUL_REV, 32'h80000000, 32'h80000000, 32'h80000000, 32 >> s});
        end
        vecs.push_back('{6, CLMUL_LO, 32'h12345678, 32'h00000001, 32'h12345678, 1});
        vecs.push_back('{6, CLMUL_LO, 32'h00000001, 32'h00000100, 32'h00000100, 3});
        vecs.push_back('{6, CLMUL_HI, 32'hdeadbeef, 32'h00000000, 32'h00000000, 1});
        vecs.push_back('{6, CLMUL_LO, 32'hdeadbeef, 32'h00000000, 32'h00000000, 1});

        // Reset state
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("reset_ready_%0d", i), 64'(ready_oa[i]), 64'd1);
            chk($sformatf("reset_valid_%0d", i), 64'(valid_oa[i]), 64'd0);
            chk($sformatf("reset_result_%0d", i), 64'(res_a[i]), 64'd0);
        end
        chk("nozbc_ready_reset", 64'(ready_oa[7]), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Directed vectors
        foreach (vecs[i]) begin
            do_op(vecs[i].k, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat,
                  $sformatf("vec%0d", i));
        end

        // Randomised against the reference model
        for (int i = 0; i < 40; i++) begin
            k   = $urandom_range(0, 6);
            rop = clmul_op_e'($urandom_range(0, 2));
            ra  = $urandom;
            rb  = $urandom;
            if ((i % 4) == 0) rb = rb >> $urandom_range(0, 31);
            do_op(k, rop, ra, rb, ref_clmul(rop, ra, rb), ref_lat(step_of(k), k == 6, rb),
                  $sformatf("rand%0d", i));
        end

        // Backpressure: result held stable for 5 cycles
        ready_a[2] = 1'b0;
        issue(2, CLMUL_LO, 32'h0000f00d, 32'h00000f0f);
        wait_valid(2, lat);
        chk("bp_latency", 64'(lat), 64'd8);
        held = ref_clmul(CLMUL_LO, 32'h0000f00d, 32'h00000f0f);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_valid_%0d", c), 64'(valid_oa[2]), 64'd1);
            chk($sformatf("bp_result_%0d", c), 64'(res_a[2]), 64'(held));
            chk($sformatf("bp_ready_%0d", c), 64'(ready_oa[2]), 64'd0);
            tick();
        end
        ready_a[2] = 1'b1;
        tick();
        chk("bp_release_ready", 64'(ready_oa[2]), 64'd1);
        chk("bp_release_valid", 64'(valid_oa[2]), 64'd0);

        // Kill in BUSY
        issue(2, CLMUL_LO, 32'h11111111, 32'hffffffff);
        tick();
        tick();
        kill_a[2] = 1'b1;
        tick();
        kill_a[2] = 1'b0;
        chk("kill_busy_ready", 64'(ready_oa[2]), 64'd1);
        rose = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (valid_oa[2]) rose = 1'b1;
            tick();
        end
        chk("kill_busy_no_valid", 64'(rose), 64'd0);

        // valid_i with kill_i in IDLE is not accepted
        op_a[2] = CLMUL_LO; a_a[2] = 32'h5; b_a[2] = 32'h5;
        valid_a[2] = 1'b1;
        kill_a[2]  = 1'b1;
        tick();
        valid_a[2] = 1'b0;
        kill_a[2]  = 1'b0;
        chk("kill_idle_ready", 64'(ready_oa[2]), 64'd1);
        rose = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (valid_oa[2]) rose = 1'b1;
            tick();
        end
        chk("kill_idle_no_valid", 64'(rose), 64'd0);

        // Kill in DONE together with ready_i
        ready_a[6] = 1'b0;
        issue(6, CLMUL_HI, 32'hffffffff, 32'hffffffff);
        wait_valid(6, lat);
        chk("kill_done_latency", 64'(lat), 64'd8);
        chk("kill_done_result", 64'(res_a[6]), 64'(ref_clmul(CLMUL_HI, 32'hffffffff, 32'hffffffff)));
        ready_a[6] = 1'b1;
        kill_a[6]  = 1'b1;
        tick();
        kill_a[6]  = 1'b0;
        chk("kill_done_valid", 64'(valid_oa[6]), 64'd0);
        chk("kill_done_ready", 64'(ready_oa[6]), 64'd1);
        chk("kill_done_res0", 64'(res_a[6]), 64'd0);

        // Reset mid-BUSY, then a clean request
        issue(2, CLMUL_LO, 32'hffffffff, 32'hffffffff);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_busy_ready", 64'(ready_oa[2]), 64'd1);
        chk("rst_busy_valid", 64'(valid_oa[2]), 64'd0);
        do_op(2, CLMUL_REV, 32'h0badf00d, 32'hc0ffee01,
              ref_clmul(CLMUL_REV, 32'h0badf00d, 32'hc0ffee01), 8, "post_rst");

        // Zbc absent: never ready, never valid
        op_a[7] = CLMUL_LO; a_a[7] = 32'h3; b_a[7] = 32'h3;
        valid_a[7] = 1'b1;
        ready_a[7] = 1'b1;
        rose = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (ready_oa[7] || valid_oa[7] || (res_a[7] != 32'h0)) rose = 1'b1;
            tick();
        end
        valid_a[7] = 1'b0;
        chk("nozbc_quiet", 64'(rose), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cv32e40s_clmul_iter.md
Name: cv32e40s_clmul_iter

Overview:
- Iterative carry-less multiply unit for the RV32 Zbc instructions clmul, clmulh and clmulr.
- Sits beside the ALU in EX and is selected when the decoded ALU operator is one of the CLMUL family.
- Successor to the single-cycle Zbc path: parametrised bits-per-cycle, optional early termination and a valid/ready handshake with kill.
- Trades latency for area on CV32E40S configurations that enable Zbc.

Parameters:
- B_EXT, B_NONE, bitmanip configuration (b_ext_e). The unit is functional only when B_EXT == ZBA_ZBB_ZBC_ZBS.
- STEP, 4, rs2 bits consumed per cycle. Legal values are 1, 2, 4, 8, 16 and 32. Any other value is an elaboration error.
- EARLY_TERM, 1, when 1 the unit finishes as soon as the remaining rs2 bits are all zero.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- valid_i  input  1  request valid
- ready_o  output  1  unit can accept a request
- operator_i  input  2  clmul_op_e: CLMUL_LO, CLMUL_HI, CLMUL_REV
- op_a_i  input  32  rs1
- op_b_i  input  32  rs2
- kill_i  input  1  abort the in-flight operation (flush)
- valid_o  output  1  result valid
- ready_i  input  1  consumer accepts result
- result_o  output  32  result; 0 whenever valid_o = 0

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low on rst_n. When rst_n = 0 at a rising edge, the next state is IDLE, valid_o = 0, ready_o = 1 and all datapath registers are cleared.
- Arithmetic: P[63:0] = XOR over i = 0..31 of (op_a << i) for each i where op_b[i] = 1.
  - CLMUL_LO returns P[31:0].
  - CLMUL_HI returns P[63:32].
  - CLMUL_REV returns P[62:31].
- Registers:
  - acc: 64-bit accumulator.
  - a_sh: 64-bit shifted copy of rs1.
  - b_rem: 32-bit remaining rs2 bits.
  - op: latched operator.
  - cnt: $clog2(32/STEP)+1 bits.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: ready_o = 1. On valid_i && !kill_i, latch a_sh = {32'b0, op_a}, b_rem = op_b, acc = 0, cnt = 0, op = operator_i, then go to BUSY.
  - BUSY: each cycle, for j = 0..STEP-1, XOR (a_sh << j) into acc when b_rem[j] = 1. Then a_sh <<= STEP, b_rem >>= STEP, cnt++.
    - Go to DONE when cnt == 32/STEP-1.
    - Also go to DONE when EARLY_TERM = 1 and (b_rem >> STEP) == 0.
  - DONE: valid_o = 1 and result_o is selected from acc by op. Hold until ready_i = 1, then return to IDLE.
- Latency: with the handshake at edge T, valid_o rises after edge T+N.
  - N = 32/STEP when EARLY_TERM = 0.
  - N = max(1, ceil((msb_index(op_b)+1)/STEP)) when EARLY_TERM = 1. For op_b = 0, N = 1.
- Throughput: ready_o is high in IDLE only. The minimum spacing between accepts is N+2 cycles. There is no back-to-back accept from DONE.
- kill_i: in any state, the next state is IDLE and valid_o drops on the next cycle.
  - kill_i has priority over valid_i: a request in IDLE with kill_i = 1 is not accepted.
  - In DONE, kill_i has priority over ready_i. The result is dropped and no handshake is counted.
- Stability: while valid_o = 1 and ready_i = 0, result_o is stable. Inputs are ignored outside IDLE.
- Zbc absent (B_EXT != ZBA_ZBB_ZBC_ZBS): ready_o = 0, valid_o = 0 and result_o = 0 constantly. All logic is optimised away.
- Assertions:
  - valid_o and ready_o are never both 1.
  - result_o == 0 when valid_o == 0.
  - cnt never exceeds 32/STEP-1.

Decomposition:
- cv32e40s_pkg: add the clmul_op_e enum (CLMUL_LO = 2'b00, CLMUL_HI = 2'b01, CLMUL_REV = 2'b10) and the clmul_state_e enum (IDLE, BUSY, DONE).
- Sub-module cv32e40s_clmul_step (combinational, parameter STEP):
  - Inputs: acc_i, a_i, b_i[STEP-1:0].
  - Output: acc_o = acc_i XOR over j of (a_i << j) where b_i[j] = 1.

Test Plan:
- Basic multiply (STEP = 4, EARLY_TERM = 0): CLMUL_LO with a = 0x00000003, b = 0x00000003 -> result 0x00000005, valid_o exactly 8 cycles after accept. CLMUL_HI with the same operands -> 0x00000000.
- High bits: a = 0x80000000, b = 0x80000000 -> CLMUL_LO 0x00000000, CLMUL_HI 0x40000000, CLMUL_REV 0x80000000. Repeat for STEP in {1, 2, 4, 8, 16, 32}; latency must be 32, 16, 8, 4, 2, 1.
- Early termination (EARLY_TERM = 1, STEP = 4):
  - b = 0x00000001 -> valid_o 1 cycle after accept, result = a.
  - b = 0x00000100 -> latency 3.
  - b = 0 -> latency 1, result 0.
- Backpressure: hold ready_i = 0 for 5 cycles in DONE -> valid_o = 1 and result_o unchanged throughout, ready_o = 0. On ready_i = 1, ready_o = 1 the next cycle.
- Kill:
  - kill_i in BUSY at cycle 3 -> valid_o never rises, ready_o = 1 on the next cycle.
  - valid_i and kill_i together in IDLE -> no accept, state stays IDLE.
  - kill_i in DONE with ready_i = 1 -> no result consumed.
- Reset: rst_n = 0 for one edge mid-BUSY -> IDLE, valid_o = 0, ready_o = 1 next cycle. The next request returns the correct product. A B_EXT = ZBA_ZBB build keeps ready_o at 0 permanently.
